// File: rtl/mips_hazard_fwd_unit_if.sv
// Bundle between the ID stage / fetch control and the hazard-forwarding unit.
// The stats ports exist only when HAZ_STATS_EN is defined.
interface mips_hazard_fwd_unit_if #(
  parameter int INS_W  = 24,
  parameter int ADDR_W = 8
);
  logic [INS_W-1:0]  ins;
  logic              ins_valid;
  logic [ADDR_W-1:0] Current_Address;
  logic              interrupt;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              imm_sel;
  logic              stall;
  logic              flush;
  logic              pc_redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] epc;
  logic              int_ack;
`ifdef HAZ_STATS_EN
  logic [15:0]       stall_cnt;
  logic [7:0]        int_cnt;
`endif

  modport master (
    output ins, ins_valid, Current_Address, interrupt,
    input  mux_sel_A, mux_sel_B, imm_sel, stall, flush, pc_redirect,
           redirect_addr, epc, int_ack
`ifdef HAZ_STATS_EN
    , input stall_cnt, int_cnt
`endif
  );

  modport slave (
    input  ins, ins_valid, Current_Address, interrupt,
    output mux_sel_A, mux_sel_B, imm_sel, stall, flush, pc_redirect,
           redirect_addr, epc, int_ack
`ifdef HAZ_STATS_EN
    , output stall_cnt, int_cnt
`endif
  );
endinterface

// File: rtl/mips_hazard_fwd_unit.sv
// Forwarding, load-use stall and interrupt entry/return control for the MIPS-style pipeline.
// Optional HAZ_STATS_EN adds saturating stall and interrupt counters.
module mips_hazard_fwd_unit #(
  parameter int                INS_W   = 24,
  parameter int                ADDR_W  = 8,
  parameter int                OPC_W   = 4,
  parameter int                REG_AW  = 4,
  parameter logic [ADDR_W-1:0] INT_VEC = 8'hF0
) (
  input logic                   clk,
  input logic                   reset,
  mips_hazard_fwd_unit_if.slave bus
);

  localparam int RD_HI  = INS_W - OPC_W - 1;
  localparam int RS_HI  = RD_HI - REG_AW;
  localparam int RT_HI  = RS_HI - REG_AW;
  localparam int LOW_W  = INS_W - OPC_W - 3 * REG_AW;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_RETI = OPC_W'(4'hF);

  typedef enum logic {S_NORMAL, S_ISR} isr_state_t;

  isr_state_t        r_state;
  isr_state_t        w_stateNext;

  logic              r_exV, r_dmV, r_wbV, r_exLd;
  logic [REG_AW-1:0] r_exRd, r_dmRd, r_wbRd;
  logic              r_intPrev, r_intPend;
  logic [ADDR_W-1:0] r_epc;

  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_rd, w_rs, w_rt;
  logic              w_writes, w_usesRs, w_usesRt, w_isLoad, w_isReti;
  logic              w_stall, w_take;

  generate
    if (LOW_W > 0) begin : g_lowBits
      logic w_unusedLow;
      assign w_unusedLow = ^bus.ins[LOW_W-1:0];
    end
  endgenerate

  assign w_opc    = bus.ins[INS_W-1 -: OPC_W];
  assign w_rd     = bus.ins[RD_HI -: REG_AW];
  assign w_rs     = bus.ins[RS_HI -: REG_AW];
  assign w_rt     = bus.ins[RT_HI -: REG_AW];

  assign w_writes = bus.ins_valid && !(w_opc == OP_NOP || w_opc == OP_ST || w_opc == OP_RETI);
  assign w_usesRs = bus.ins_valid && (w_opc != OP_NOP);
  assign w_usesRt = w_usesRs && (!w_opc[OPC_W-1] || w_opc == OP_ST);
  assign w_isLoad = bus.ins_valid && (w_opc == OP_LD);
  assign w_isReti = bus.ins_valid && (w_opc == OP_RETI);

  assign w_stall  = r_exV && r_exLd && (r_exRd != '0) &&
                    ((w_usesRs && w_rs == r_exRd) || (w_usesRt && w_rt == r_exRd));
  assign w_take   = r_intPend && (r_state == S_NORMAL) && !w_stall && !w_isReti;

  // Youngest producer wins; r0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic              used,
    input logic [REG_AW-1:0] src,
    input logic              exV,
    input logic [REG_AW-1:0] exRd,
    input logic              dmV,
    input logic [REG_AW-1:0] dmRd,
    input logic              wbV,
    input logic [REG_AW-1:0] wbRd
  );
    fwdSel = 2'b00;
    if (used && src != '0) begin
      if (exV && exRd == src)      fwdSel = 2'b01;
      else if (dmV && dmRd == src) fwdSel = 2'b10;
      else if (wbV && wbRd == src) fwdSel = 2'b11;
    end
  endfunction

  always_comb begin
    w_stateNext = r_state;
    if (w_take)        w_stateNext = S_ISR;
    else if (w_isReti) w_stateNext = S_NORMAL;
  end

  always_comb begin
    bus.mux_sel_A     = 2'b00;
    bus.mux_sel_B     = 2'b00;
    bus.imm_sel       = 1'b0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.pc_redirect   = 1'b0;
    bus.redirect_addr = '0;
    bus.int_ack       = 1'b0;
    if (reset) begin
      bus.mux_sel_A = fwdSel(w_usesRs, w_rs, r_exV, r_exRd, r_dmV, r_dmRd, r_wbV, r_wbRd);
      bus.mux_sel_B = fwdSel(w_usesRt, w_rt, r_exV, r_exRd, r_dmV, r_dmRd, r_wbV, r_wbRd);
      bus.imm_sel   = w_opc[OPC_W-1] && (w_opc != OP_RETI);
      bus.stall     = w_stall;
      if (w_take) begin
        bus.flush         = 1'b1;
        bus.pc_redirect   = 1'b1;
        bus.redirect_addr = INT_VEC;
        bus.int_ack       = 1'b1;
      end else if (w_isReti) begin
        bus.pc_redirect   = 1'b1;
        bus.redirect_addr = r_epc;
      end
    end
  end

  assign bus.epc = r_epc;

  // Only EX needs is_load: by DM a load result is forwardable like any other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_NORMAL;
      r_exV     <= 1'b0;
      r_exRd    <= '0;
      r_exLd    <= 1'b0;
      r_dmV     <= 1'b0;
      r_dmRd    <= '0;
      r_wbV     <= 1'b0;
      r_wbRd    <= '0;
      r_intPrev <= 1'b0;
      r_intPend <= 1'b0;
      r_epc     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_wbV     <= r_dmV;
      r_wbRd    <= r_dmRd;
      r_dmV     <= r_exV;
      r_dmRd    <= r_exRd;
      r_exV     <= w_writes && !w_stall && !w_take;
      r_exRd    <= w_rd;
      r_exLd    <= w_isLoad && !w_stall && !w_take;
      r_intPrev <= bus.interrupt;
      r_intPend <= (r_intPend && !w_take) || (bus.interrupt && !r_intPrev);
      if (w_take) r_epc <= bus.Current_Address;
    end
  end

`ifdef HAZ_STATS_EN
  logic [15:0] r_stallCnt;
  logic [7:0]  r_intCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCnt <= '0;
      r_intCnt   <= '0;
    end else begin
      if (w_stall && !(&r_stallCnt)) r_stallCnt <= r_stallCnt + 16'd1;
      if (w_take && !(&r_intCnt))    r_intCnt   <= r_intCnt + 8'd1;
    end
  end

  assign bus.stall_cnt = r_stallCnt;
  assign bus.int_cnt   = r_intCnt;
`endif

endmodule

// File: tb/tb_mips_hazard_fwd_unit.sv
// Directed bench for mips_hazard_fwd_unit: forwarding, load-use stall, interrupt entry/return, reset.
module tb_mips_hazard_fwd_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clk = ~clk;

  mips_hazard_fwd_unit_if busIf ();

  mips_hazard_fwd_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf.slave)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Drive one ID-stage cycle at the falling edge; outputs are checked 1ns later.
  task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [3:0] rt, input logic valid, input logic [7:0] addr,
                               input logic intr);
    @(negedge clk);
    busIf.ins             = {opc, rd, rs, rt, 8'h00};
    busIf.ins_valid       = valid;
    busIf.Current_Address = addr;
    busIf.interrupt       = intr;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset                 = 1'b0;
    busIf.ins             = '0;
    busIf.ins_valid       = 1'b0;
    busIf.Current_Address = '0;
    busIf.interrupt       = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    busIf.ins             = '0;
    busIf.ins_valid       = 1'b0;
    busIf.Current_Address = '0;
    busIf.interrupt       = 1'b0;

    // Outputs held at zero while reset is low, even with a live instruction.
    #2;
    busIf.ins       = {4'h1, 4'h1, 4'h1, 4'h1, 8'h00};
    busIf.ins_valid = 1'b1;
    #1;
    checkOutput("rst_muxA", 16'(busIf.mux_sel_A), 16'h0);
    checkOutput("rst_imm", 16'(busIf.imm_sel), 16'h0);
    checkOutput("rst_epc", 16'(busIf.epc), 16'h0);
    doReset();

    applyStimulus(4'h1, 4'd1, 4'd2, 4'd3, 1'b1, 8'h00, 1'b0);
    checkOutput("first_muxA", 16'(busIf.mux_sel_A), 16'h0);
    applyStimulus(4'h1, 4'd4, 4'd1, 4'd1, 1'b1, 8'h01, 1'b0);
    checkOutput("b2b_muxA", 16'(busIf.mux_sel_A), 16'h1);
    checkOutput("b2b_muxB", 16'(busIf.mux_sel_B), 16'h1);
    checkOutput("b2b_stall", 16'(busIf.stall), 16'h0);
    applyStimulus(4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 8'h02, 1'b0);
    applyStimulus(4'h2, 4'd5, 4'd1, 4'd2, 1'b1, 8'h03, 1'b0);
    checkOutput("wb_muxA", 16'(busIf.mux_sel_A), 16'h3);
    checkOutput("wb_muxB", 16'(busIf.mux_sel_B), 16'h0);
    applyStimulus(4'h1, 4'd8, 4'd2, 4'd3, 1'b1, 8'h04, 1'b0);
    applyStimulus(4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 8'h05, 1'b0);
    applyStimulus(4'h2, 4'd9, 4'd8, 4'd0, 1'b1, 8'h06, 1'b0);
    checkOutput("dm_muxA", 16'(busIf.mux_sel_A), 16'h2);
    checkOutput("dm_muxB_r0", 16'(busIf.mux_sel_B), 16'h0);
    applyStimulus(4'h1, 4'd9, 4'd9, 4'd8, 1'b1, 8'h07, 1'b0);
    checkOutput("ex_muxA", 16'(busIf.mux_sel_A), 16'h1);
    checkOutput("wb_muxB", 16'(busIf.mux_sel_B), 16'h3);
    applyStimulus(4'h1, 4'd9, 4'd9, 4'd9, 1'b1, 8'h08, 1'b0);
    checkOutput("prio_muxA", 16'(busIf.mux_sel_A), 16'h1);

    // Load-use: one stall cycle, then DM forwarding.
    applyStimulus(4'hA, 4'd3, 4'd2, 4'd0, 1'b1, 8'h09, 1'b0);
    applyStimulus(4'h1, 4'd6, 4'd3, 4'd0, 1'b1, 8'h0A, 1'b0);
    checkOutput("lu_stall", 16'(busIf.stall), 16'h1);
    applyStimulus(4'h1, 4'd6, 4'd3, 4'd0, 1'b1, 8'h0A, 1'b0);
    checkOutput("lu_stall_end", 16'(busIf.stall), 16'h0);
    checkOutput("lu_muxA", 16'(busIf.mux_sel_A), 16'h2);
    checkOutput("lu_muxB", 16'(busIf.mux_sel_B), 16'h0);
    applyStimulus(4'hA, 4'd3, 4'd2, 4'd0, 1'b1, 8'h0B, 1'b0);
    applyStimulus(4'h8, 4'd7, 4'd3, 4'd0, 1'b1, 8'h0C, 1'b0);
    checkOutput("addi_stall", 16'(busIf.stall), 16'h1);
    checkOutput("addi_imm", 16'(busIf.imm_sel), 16'h1);
    applyStimulus(4'h8, 4'd7, 4'd3, 4'd0, 1'b1, 8'h0C, 1'b0);
    checkOutput("addi_muxA", 16'(busIf.mux_sel_A), 16'h2);

    // r0 is never forwarded and never stalls.
    applyStimulus(4'h1, 4'd0, 4'd1, 4'd2, 1'b1, 8'h0D, 1'b0);
    applyStimulus(4'h1, 4'd10, 4'd0, 4'd0, 1'b1, 8'h0E, 1'b0);
    checkOutput("r0_muxA", 16'(busIf.mux_sel_A), 16'h0);
    checkOutput("r0_muxB", 16'(busIf.mux_sel_B), 16'h0);
    applyStimulus(4'hA, 4'd0, 4'd1, 4'd0, 1'b1, 8'h0F, 1'b0);
    applyStimulus(4'h1, 4'd11, 4'd0, 4'd0, 1'b1, 8'h10, 1'b0);
    checkOutput("r0_ld_stall", 16'(busIf.stall), 16'h0);

    // Interrupt entry, nested request held off, RETI, then deferred entry.
    doReset();
    applyStimulus(4'h1, 4'd1, 4'd2, 4'd3, 1'b1, 8'h20, 1'b1);
    checkOutput("irq_rise_ack", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'h1, 4'd1, 4'd2, 4'd3, 1'b1, 8'h24, 1'b1);
    checkOutput("irq_flush", 16'(busIf.flush), 16'h1);
    checkOutput("irq_redir", 16'(busIf.pc_redirect), 16'h1);
    checkOutput("irq_addr", 16'(busIf.redirect_addr), 16'hF0);
    checkOutput("irq_ack", 16'(busIf.int_ack), 16'h1);
    applyStimulus(4'h1, 4'd2, 4'd3, 4'd4, 1'b1, 8'hF0, 1'b1);
    checkOutput("irq_epc", 16'(busIf.epc), 16'h24);
    checkOutput("irq_ack_once", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'h1, 4'd2, 4'd3, 4'd4, 1'b1, 8'hF1, 1'b0);
    applyStimulus(4'h1, 4'd2, 4'd3, 4'd4, 1'b1, 8'hF2, 1'b1);
    applyStimulus(4'h1, 4'd2, 4'd3, 4'd4, 1'b1, 8'hF3, 1'b1);
    checkOutput("nest_ack", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 8'hF4, 1'b1);
    checkOutput("reti_redir", 16'(busIf.pc_redirect), 16'h1);
    checkOutput("reti_addr", 16'(busIf.redirect_addr), 16'h24);
    checkOutput("reti_flush", 16'(busIf.flush), 16'h0);
    checkOutput("reti_ack", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'h1, 4'd1, 4'd2, 4'd3, 1'b1, 8'h28, 1'b1);
    checkOutput("irq2_ack", 16'(busIf.int_ack), 16'h1);
    checkOutput("irq2_addr", 16'(busIf.redirect_addr), 16'hF0);
    applyStimulus(4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 8'hF0, 1'b1);
    checkOutput("irq2_epc", 16'(busIf.epc), 16'h28);
    checkOutput("irq2_reti_addr", 16'(busIf.redirect_addr), 16'h28);

    // Asynchronous reset in the middle of the ISR.
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_redir", 16'(busIf.pc_redirect), 16'h0);
    checkOutput("mid_rst_addr", 16'(busIf.redirect_addr), 16'h0);
    checkOutput("mid_rst_epc", 16'(busIf.epc), 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // Interrupt pending during a load-use stall waits for the stall to clear.
    doReset();
    applyStimulus(4'hA, 4'd3, 4'd2, 4'd0, 1'b1, 8'h40, 1'b1);
    checkOutput("ldirq_ack0", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'h1, 4'd6, 4'd3, 4'd0, 1'b1, 8'h41, 1'b1);
    checkOutput("ldirq_stall", 16'(busIf.stall), 16'h1);
    checkOutput("ldirq_defer", 16'(busIf.int_ack), 16'h0);
    applyStimulus(4'h1, 4'd6, 4'd3, 4'd0, 1'b1, 8'h41, 1'b1);
    checkOutput("ldirq_take", 16'(busIf.int_ack), 16'h1);
    checkOutput("ldirq_flush", 16'(busIf.flush), 16'h1);
    applyStimulus(4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 8'hF0, 1'b1);
    checkOutput("ldirq_epc", 16'(busIf.epc), 16'h41);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
